shiftright_seq_ctrl: RTL and testbench
======================================

// Module: shiftright_seq_ctrl
// PURPOSE
//   Sequences the 4-bit right-shift register: accepts a parallel word over a valid/ready
//   handshake, then drives the register's serial input and shift enable one bit per cycle.
//   Gives the register a frame-level interface so upstream logic never touches bit timing.
//   LSB-first feed into a right-shift register leaves the register holding the original word.
// PARAMETERS
//   WIDTH      4   bits per frame; must be >= 2
//   LSB_FIRST  1   1: bit 0 shifted out first; 0: bit WIDTH-1 first
//   IDLE_GAP   1   dead cycles after each frame before in_ready reasserts (0..15)
// PORTS
//   clk          in   1      single clock; all state updates on rising edge
//   rst          in   1      synchronous, active-low reset
//   in_valid     in   1      upstream word valid
//   in_ready     out  1      controller can accept a word (combinational: state==IDLE)
//   in_data      in   WIDTH  parallel word; sampled on accept edge only
//   sh_hold      in   1      stall request; freezes shifting while high
//   sh_bit       out  1      serial bit to shift register input (a)
//   sh_en        out  1      shift enable to shift register
//   frame_start  out  1      1-cycle pulse, first SHIFT cycle of a frame
//   frame_done   out  1      1-cycle pulse, cycle after final shift
//   busy         out  1      high in any state other than IDLE
// BEHAVIOUR
//   - Reset (rst==0 at edge): state=IDLE, data_q=0, bit_cnt=0, gap_cnt=0; sh_bit, sh_en,
//     frame_start, frame_done, busy all 0. in_ready reads 1 in IDLE, but no accept while rst==0.
//   - Reset mid-frame aborts immediately; partial frame discarded, no frame_done.
//   - States: IDLE -> SHIFT -> [PAR] -> GAP -> IDLE. GAP skipped when IDLE_GAP==0.
//   - IDLE: accept when in_valid && in_ready at edge; data_q<=in_data, bit_cnt<=0, go SHIFT.
//   - Latency: accept at edge N; first sh_en=1 in cycle N+1; frame_start=1 in cycle N+1.
//   - SHIFT: sh_en = !sh_hold (combinational). sh_bit = data_q[0] (LSB_FIRST) else data_q[WIDTH-1].
//     Each cycle with sh_en=1: data_q shifts toward the output bit, bit_cnt++.
//     After the shift with bit_cnt==WIDTH-1: go PAR if enabled, else GAP/IDLE.
//   - sh_hold: sh_en=0, data_q and bit_cnt frozen, sh_bit held stable; no cycle limit.
//     frame_start not re-pulsed after a hold in the first cycle.
//   - frame_done: registered 1-cycle pulse in the cycle after the final sh_en=1 cycle.
//   - GAP: in_ready=0 for exactly IDLE_GAP cycles, counted by gap_cnt, then IDLE.
//   - Minimum frame period: WIDTH + IDLE_GAP + 1 cycles (+1 with parity), no holds.
//   - in_valid ignored outside IDLE; in_data changes outside accept edge have no effect.
//   - sh_bit=0 and sh_en=0 in IDLE and GAP.
// CONFIGURATION
//   SHIFTRIGHT_SEQ_PARITY_EN defined: after WIDTH data bits, PAR state shifts one extra bit =
//     even parity (XOR of accepted word); sh_hold applies identically. frame_done follows parity bit.
//   Not defined: no PAR state, exactly WIDTH shifts per frame, no parity logic synthesized.
// TESTING  (WIDTH=4, LSB_FIRST=1, IDLE_GAP=1, macro off unless stated)
//   1 reset: hold rst=0 2 cycles with in_valid=1 -> no accept, all outputs 0, busy=0, in_ready=1
//   2 in_data=4'b0011 accepted -> sh_bit 1,1,0,0 over 4 sh_en cycles; frame_done next cycle;
//     attached shift register out=4'b0011
//   3 in_data=4'b1010 with sh_hold=1 cycles 2-3 of SHIFT -> sh_en low 2 cycles, sh_bit held,
//     sequence 0,1,0,1 intact, frame_done 2 cycles later than test 2
//   4 back-to-back words, in_valid held 1 -> in_ready low 4 SHIFT + 1 GAP cycles; accepts spaced 6 cycles
//   5 rst=0 after 2nd shift bit -> next cycle IDLE, busy=0, no frame_done; next word shifts cleanly
//   6 macro on, in_data=4'b0111 -> 5 shifts: 1,1,1,0 then parity 1; frame_done after 5th

Source files
------------

// File: rtl/shiftright_seq_if.sv
// shiftright_seq_if: frame-level bundle between upstream logic, the sequencer
// and the 4-bit right-shift register it feeds.
//   in_valid/in_ready/in_data : word handshake. A word moves on a rising edge
//                               where in_valid && in_ready are both high. in_valid
//                               may rise at any time and is ignored while in_ready
//                               is low. in_data only matters on that edge.
//   sh_hold                   : stall request from the register side.
//   sh_bit/sh_en              : serial bit and shift enable to the register.
//   frame_start/frame_done    : single-cycle frame markers.
//   busy                      : sequencer is not idle.
// Modports: master = upstream/register side, slave = sequencer.
interface shiftright_seq_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sh_hold;
  logic             sh_bit;
  logic             sh_en;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    output in_valid, in_data, sh_hold,
    input  in_ready, sh_bit, sh_en, frame_start, frame_done, busy
  );

  modport slave (
    input  in_valid, in_data, sh_hold,
    output in_ready, sh_bit, sh_en, frame_start, frame_done, busy
  );
endinterface

// File: rtl/shiftright_seq_ctrl.sv
// shiftright_seq_ctrl: accepts a parallel word and feeds it one bit per cycle
// into a right-shift register. Feeding LSB first leaves the register holding
// the original word once the frame completes.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous, active-low reset
//   bus        : shiftright_seq_if.slave (handshake, shift outputs, markers)
//   state_dbg  : current FSM state (0 IDLE, 1 SHIFT, 2 PAR, 3 GAP)
// Parameters: WIDTH (>= 2), LSB_FIRST, IDLE_GAP (0..15 dead cycles per frame).
// Optional feature: define SHIFTRIGHT_SEQ_PARITY_EN to append an even-parity
// bit (XOR of the accepted word) after the data bits.
module shiftright_seq_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter int IDLE_GAP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  shiftright_seq_if.slave    bus,
  output logic [1:0]         state_dbg
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = 4'(IDLE_GAP - 1);
  // State entered once the last bit of a frame has been shifted.
  localparam state_t POST_FRAME = (IDLE_GAP == 0) ? IDLE : GAP;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             out_bit;
  logic             shifting;

  assign out_bit  = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];
  assign shifting = (state == SHIFT) || (state == PAR);

  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.sh_en    = shifting && !bus.sh_hold;
  assign state_dbg    = state;

`ifdef SHIFTRIGHT_SEQ_PARITY_EN
  logic par_q;
  assign bus.sh_bit = (state == SHIFT) ? out_bit :
                      (state == PAR)   ? par_q   : 1'b0;
`else
  assign bus.sh_bit = (state == SHIFT) ? out_bit : 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      data_q          <= '0;
      bit_cnt         <= '0;
      gap_cnt         <= '0;
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
`ifdef SHIFTRIGHT_SEQ_PARITY_EN
      par_q           <= 1'b0;
`endif
    end else begin
      bus.frame_start <= 1'b0;
      bus.frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          // in_ready is high throughout IDLE, so in_valid alone accepts.
          if (bus.in_valid) begin
            data_q          <= bus.in_data;
            bit_cnt         <= '0;
            state           <= SHIFT;
            bus.frame_start <= 1'b1;
`ifdef SHIFTRIGHT_SEQ_PARITY_EN
            par_q           <= ^bus.in_data;
`endif
          end
        end
        SHIFT: begin
          // A hold freezes data_q and bit_cnt, so sh_bit stays stable.
          if (!bus.sh_hold) begin
            data_q  <= LSB_FIRST ? (data_q >> 1) : (data_q << 1);
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
`ifdef SHIFTRIGHT_SEQ_PARITY_EN
              state          <= PAR;
`else
              state          <= POST_FRAME;
              gap_cnt        <= '0;
              bus.frame_done <= 1'b1;
`endif
            end
          end
        end
`ifdef SHIFTRIGHT_SEQ_PARITY_EN
        PAR: begin
          if (!bus.sh_hold) begin
            state          <= POST_FRAME;
            gap_cnt        <= '0;
            bus.frame_done <= 1'b1;
          end
        end
`endif
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shiftright_seq_ctrl.sv
// tb_shiftright_seq_ctrl: directed bench for shiftright_seq_ctrl with WIDTH=4,
// LSB_FIRST=1, IDLE_GAP=1. Expected serial bits are queued per frame and
// popped on every sh_en cycle; a 4-bit right-shift register model sits on
// sh_bit/sh_en to show the word arrives intact.
module tb_shiftright_seq_ctrl;
  localparam int W = 4;
`ifdef SHIFTRIGHT_SEQ_PARITY_EN
  localparam int NS = 5;
`else
  localparam int NS = 4;
`endif
  localparam int PER = NS + 2;  // shifts + one gap cycle + one idle cycle

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] state_dbg;
  int         errors = 0;
  int         checks = 0;
  logic [0:0] exp_q[$];

  shiftright_seq_if #(.WIDTH(W)) bus ();

  shiftright_seq_ctrl #(
    .WIDTH(W), .LSB_FIRST(1'b1), .IDLE_GAP(1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [3:0] d, input logic p);
    for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
    if (NS == 5) exp_q.push_back(p);
  endtask

  // Offers one word, then watches the frame cycle by cycle until frame_done.
  task automatic run_frame(input logic [3:0] d, input logic [15:0] hold_mask,
                           output int n_shift, output int done_cyc,
                           output int start_cyc, output int start_cnt,
                           output logic [3:0] sr);
    logic [0:0] e;
    n_shift = 0; done_cyc = -1; start_cyc = -1; start_cnt = 0; sr = '0;
    bus.in_valid = 1'b1; bus.in_data = d; bus.sh_hold = 1'b0;
    #1 check_eq("accept_ready", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 4'hF;
    for (int c = 1; c < 40 && done_cyc < 0; c++) begin
      bus.sh_hold = hold_mask[c];
      #1;
      if (bus.frame_start) begin start_cnt++; start_cyc = c; end
      if (hold_mask[c]) begin
        check_eq("hold_en", int'(bus.sh_en), 0);
        if (exp_q.size() > 0) check_eq("hold_bit", int'(bus.sh_bit), int'(exp_q[0]));
      end
      if (bus.sh_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("sh_bit", int'(bus.sh_bit), int'(e));
        end
        sr = {bus.sh_bit, sr[3:1]};
        n_shift++;
      end
      if (bus.frame_done) done_cyc = c;
      if (done_cyc < 0) tick();
    end
    bus.sh_hold = 1'b0;
  endtask

  int         n_shift, done_cyc, start_cyc, start_cnt, low_cnt, fd_cnt;
  logic [3:0] sr;
  int         acc[$];

  initial begin
    bus.in_valid = 1'b1; bus.in_data = 4'h5; bus.sh_hold = 1'b0;
    // 1: reset held two cycles with in_valid high
    tick(); tick();
    check_eq("rst_state", int'(state_dbg), 0);
    check_eq("rst_busy", int'(bus.busy), 0);
    check_eq("rst_ready", int'(bus.in_ready), 1);
    check_eq("rst_sh_en", int'(bus.sh_en), 0);
    check_eq("rst_sh_bit", int'(bus.sh_bit), 0);
    check_eq("rst_start", int'(bus.frame_start), 0);
    check_eq("rst_done", int'(bus.frame_done), 0);
    rst = 1'b1; bus.in_valid = 1'b0;
    tick();
    check_eq("post_rst_idle", int'(state_dbg), 0);

    // 2: plain frame 0011
    push_bits(4'b0011, 1'b0);
    run_frame(4'b0011, 16'h0000, n_shift, done_cyc, start_cyc, start_cnt, sr);
    check_eq("t2_shifts", n_shift, NS);
    check_eq("t2_done_cyc", done_cyc, NS + 1);
    check_eq("t2_start_cyc", start_cyc, 1);
    check_eq("t2_start_cnt", start_cnt, 1);
`ifndef SHIFTRIGHT_SEQ_PARITY_EN
    check_eq("t2_sreg", int'(sr), 4'b0011);
`endif
    check_eq("t2_gap_ready", int'(bus.in_ready), 0);
    check_eq("t2_gap_busy", int'(bus.busy), 1);
    check_eq("t2_gap_sh_en", int'(bus.sh_en), 0);
    tick();
    check_eq("t2_back_idle", int'(bus.in_ready), 1);

    // 3: frame 1010 with hold in SHIFT cycles 2-3
    push_bits(4'b1010, 1'b0);
    run_frame(4'b1010, 16'h000C, n_shift, done_cyc, start_cyc, start_cnt, sr);
    check_eq("t3_shifts", n_shift, NS);
    check_eq("t3_done_cyc", done_cyc, NS + 3);
    check_eq("t3_start_cnt", start_cnt, 1);
`ifndef SHIFTRIGHT_SEQ_PARITY_EN
    check_eq("t3_sreg", int'(sr), 4'b1010);
`endif
    tick();

    // 4: back-to-back words with in_valid held high
    bus.in_valid = 1'b1; bus.in_data = 4'b1100;
    low_cnt = 0;
    for (int t = 0; t <= 3 * PER; t++) begin
      #1;
      if (bus.in_ready) acc.push_back(t);
      else if (acc.size() == 1) low_cnt++;
      tick();
    end
    bus.in_valid = 1'b0;
    check_eq("t4_accepts", acc.size(), 4);
    if (acc.size() >= 3) begin
      check_eq("t4_space1", acc[1] - acc[0], PER);
      check_eq("t4_space2", acc[2] - acc[1], PER);
    end
    check_eq("t4_low_cycles", low_cnt, PER - 1);
    for (int i = 0; i < 30 && bus.busy; i++) tick();
    check_eq("t4_drained", int'(bus.busy), 0);

    // 5: reset after the second shifted bit
    bus.in_valid = 1'b1; bus.in_data = 4'b1001;
    tick();
    bus.in_valid = 1'b0;
    #1 check_eq("t5_bit1", int'(bus.sh_bit), 1);
    tick();
    #1 check_eq("t5_bit2", int'(bus.sh_bit), 0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("t5_rst_state", int'(state_dbg), 0);
    check_eq("t5_rst_busy", int'(bus.busy), 0);
    check_eq("t5_rst_done", int'(bus.frame_done), 0);
    rst = 1'b1;
    fd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.frame_done || bus.busy) fd_cnt++;
    end
    check_eq("t5_quiet", fd_cnt, 0);
    push_bits(4'b0110, 1'b0);
    run_frame(4'b0110, 16'h0000, n_shift, done_cyc, start_cyc, start_cnt, sr);
    check_eq("t5_shifts", n_shift, NS);
    check_eq("t5_done_cyc", done_cyc, NS + 1);
`ifndef SHIFTRIGHT_SEQ_PARITY_EN
    check_eq("t5_sreg", int'(sr), 4'b0110);
`endif
    tick();

    // 6: word 0111, parity bit 1 when enabled
    push_bits(4'b0111, 1'b1);
    run_frame(4'b0111, 16'h0000, n_shift, done_cyc, start_cyc, start_cnt, sr);
    check_eq("t6_shifts", n_shift, NS);
    check_eq("t6_done_cyc", done_cyc, NS + 1);
`ifdef SHIFTRIGHT_SEQ_PARITY_EN
    check_eq("t6_sreg", int'(sr), 4'b1011);
`else
    check_eq("t6_sreg", int'(sr), 4'b0111);
`endif
    tick();

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
